// File: rtl/guess_pkg.sv
// Shared types and helpers for the guess scorer: FSM states, default sizes,
// and the count-to-thermometer helper used for the LED result view.
package guess_pkg;

    localparam int unsigned DEF_DIGITS = 3;
    localparam int unsigned DEF_DW     = 4;
    localparam int unsigned MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        EXACT,
        CROSS,
        FINISH
    } state_t;

    // Callers size-cast the result down to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] therm(input int unsigned count);
        logic [MAX_DIGITS-1:0] t;
        t = '0;
        for (int unsigned b = 0; b < MAX_DIGITS; b++) begin
            t[b] = (b < count);
        end
        return t;
    endfunction

endpackage

// File: rtl/guess_pair_scan.sv
// (i, j) index walker for the cross-match phase: j runs fastest, i outer;
// last_pair flags the final (DIGITS-1, DIGITS-1) pair.
module guess_pair_scan
    import guess_pkg::*;
#(
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last_pair
);

    logic i_last;
    logic j_last;

    always_comb begin
        i_last    = (i == IW'(DIGITS - 1));
        j_last    = (j == IW'(DIGITS - 1));
        last_pair = i_last && j_last;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
        end else if (step) begin
            if (j_last) begin
                j <= '0;
                i <= i_last ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/guess_checker.sv
// Mastermind-style scorer: exact pass, then cross pass over all digit pairs.
// Optional GUESS_TRIES_EN adds a saturating count of completed scorings.
module guess_checker
    import guess_pkg::*;
#(
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned DW     = DEF_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIGITS*DW-1:0]   input_number,
    input  logic [DIGITS*DW-1:0]   target_number,
    output logic                   busy,
    output logic                   done,
    output logic [2*DIGITS-1:0]    check_result,
`ifdef GUESS_TRIES_EN
    output logic                   win,
    output logic [7:0]             tries
`else
    output logic                   win
`endif
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t state;
    state_t state_next;

    logic [DIGITS*DW-1:0] g_reg;
    logic [DIGITS*DW-1:0] t_reg;
    logic [DW-1:0]        gd [DIGITS];
    logic [DW-1:0]        td [DIGITS];
    logic [DIGITS-1:0]    gused;
    logic [DIGITS-1:0]    tused;
    logic [CW-1:0]        exact;
    logic [CW-1:0]        misp;
    logic [KW-1:0]        k;
    logic [KW-1:0]        pi;
    logic [KW-1:0]        pj;
    logic                 last_pair;

    always_comb begin
        for (int unsigned d = 0; d < DIGITS; d++) begin
            gd[d] = g_reg[d*DW +: DW];
            td[d] = t_reg[d*DW +: DW];
        end
    end

    guess_pair_scan #(
        .DIGITS (DIGITS),
        .IW     (KW)
    ) u_pair_scan (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .step      (state == CROSS),
        .i         (pi),
        .j         (pj),
        .last_pair (last_pair)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE) || done;
        unique case (state)
            IDLE:    if (start) state_next = EXACT;
            EXACT:   if (k == KW'(DIGITS - 1)) state_next = CROSS;
            CROSS:   if (last_pair) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_reg        <= '0;
            t_reg        <= '0;
            gused        <= '0;
            tused        <= '0;
            exact        <= '0;
            misp         <= '0;
            k            <= '0;
            done         <= 1'b0;
            win          <= 1'b0;
            check_result <= '0;
        end else begin
            done <= 1'b0;
            win  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        g_reg <= input_number;
                        t_reg <= target_number;
                        gused <= '0;
                        tused <= '0;
                        exact <= '0;
                        misp  <= '0;
                        k     <= '0;
                    end
                end
                EXACT: begin
                    if (gd[k] == td[k]) begin
                        exact    <= exact + 1'b1;
                        gused[k] <= 1'b1;
                        tused[k] <= 1'b1;
                    end
                    k <= k + 1'b1;
                end
                CROSS: begin
                    // Used flags keep each digit on either side to one match.
                    if (!gused[pi] && !tused[pj] && gd[pi] == td[pj]) begin
                        misp      <= misp + 1'b1;
                        gused[pi] <= 1'b1;
                        tused[pj] <= 1'b1;
                    end
                end
                FINISH: begin
                    check_result <= {DIGITS'(therm(32'(exact))), DIGITS'(therm(32'(misp)))};
                    done         <= 1'b1;
                    win          <= (exact == CW'(DIGITS));
                end
                default: ;
            endcase
        end
    end

`ifdef GUESS_TRIES_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tries <= '0;
        end else if (state == FINISH && tries != 8'hFF) begin
            tries <= tries + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_guess_checker.sv
// Randomized scoreboard bench for guess_checker; expected scores come from a
// digit-histogram model of the game rules.
module tb_guess_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] input_number = '0;
    logic [11:0] target_number = '0;
    logic        busy;
    logic        done;
    logic [5:0]  check_result;
    logic        win;
`ifdef GUESS_TRIES_EN
    logic [7:0]  tries;
`endif

    guess_checker #(.DIGITS(3), .DW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .input_number  (input_number),
        .target_number (target_number),
        .busy          (busy),
        .done          (done),
        .check_result  (check_result),
`ifdef GUESS_TRIES_EN
        .win           (win),
        .tries         (tries)
`else
        .win           (win)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  cr;
        logic        win;
        int unsigned acc;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    logic        rst_q = 1'b1;
    logic [5:0]  exp_cr = '0;
    int unsigned exp_tries = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Exact hits are positional; misplaced hits are the per-value overlap of
    // the leftover digits on both sides.
    function automatic logic [5:0] model(input logic [11:0] g, input logic [11:0] t);
        int ex = 0;
        int mi = 0;
        int gc[16];
        int tc[16];
        logic [5:0] r;
        for (int v = 0; v < 16; v++) begin gc[v] = 0; tc[v] = 0; end
        for (int d = 0; d < 3; d++) begin
            int gv = int'((g >> (4*d)) & 12'hF);
            int tv = int'((t >> (4*d)) & 12'hF);
            if (gv == tv) ex++;
            else begin gc[gv]++; tc[tv]++; end
        end
        for (int v = 0; v < 16; v++) mi += (gc[v] < tc[v]) ? gc[v] : tc[v];
        r[5:3] = 3'((1 << ex) - 1);
        r[2:0] = 3'((1 << mi) - 1);
        return r;
    endfunction

    always @(negedge clk) begin
        bit   popped;
        bit   exp_busy;
        exp_t e;
        if (rst_q) begin
            q.delete();
            exp_cr    = '0;
            exp_tries = 0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_win", 32'(win), 32'd0);
            check("rst_result", 32'(check_result), 32'd0);
        end else begin
            popped = 1'b0;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    popped = 1'b1;
                    check("done_cycle", cyc, e.due);
                    check("win", 32'(win), 32'(e.win));
                    exp_cr = e.cr;
                    if (exp_tries < 255) exp_tries++;
                end
            end else begin
                check("win_without_done", 32'(win), 32'd0);
                if (q.size() > 0 && cyc > q[0].due) begin
                    check("missing_done", 32'(done), 32'd1);
                    void'(q.pop_front());
                end
            end
            exp_busy = popped;
            foreach (q[n]) if (cyc >= q[n].acc) exp_busy = 1'b1;
            check("busy", 32'(busy), 32'(exp_busy));
            check("check_result", 32'(check_result), 32'(exp_cr));
`ifdef GUESS_TRIES_EN
            check("tries", 32'(tries), exp_tries);
`endif
        end
    end

    task automatic issue(input logic [11:0] g, input logic [11:0] t, input bit push);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        input_number = g;
        target_number = t;
        if (push) begin
            e.cr  = model(g, t);
            e.win = (g == t);
            e.acc = cyc + 1;
            e.due = cyc + 14;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 40 && q.size() != 0; n++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout cycle=%0d pending=%0d expected=0", cyc, q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [11:0] rand_num();
        logic [11:0] r;
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 3));
        end
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] g;
        logic [11:0] t;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(12'h123, 12'h123, 1'b1);
        wait_done();
        issue(12'h321, 12'h123, 1'b1);
        wait_done();
        issue(12'h111, 12'h100, 1'b1);
        wait_done();
        issue(12'h221, 12'h122, 1'b1);
        wait_done();

        issue(12'h456, 12'h123, 1'b1);
        wait_done();
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            input_number  = 12'($urandom);
            target_number = 12'($urandom);
        end

        // Second start mid-scoring must be dropped.
        issue(12'h321, 12'h123, 1'b1);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        input_number = 12'h999;
        @(posedge clk); #1 start = 1'b0;
        wait_done();

        // Reset aborts the first scoring; a fresh start then completes.
        issue(12'h123, 12'h123, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        issue(12'h231, 12'h123, 1'b1);
        wait_done();

        for (int n = 0; n < 150; n++) begin
            t = rand_num();
            g = ($urandom_range(0, 7) == 0) ? t : rand_num();
            issue(g, t, 1'b1);
            input_number  = 12'($urandom);
            target_number = 12'($urandom);
            if ($urandom_range(0, 2) == 0) repeat (12) @(posedge clk);
            else wait_done();
        end
        wait_done();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Sequential scorer for the number-guessing game. Compares a 3-digit BCD guess (switch shift register) against the 3-digit random target, Mastermind style.
- Sits between the operand sources (shift register, random generator) and the game control FSM. Control pulses start and later consumes done/check_result/win.
- check_result drives the LED result view directly.

Parameters:
- DIGITS, 3, number of digits compared.
- DW, 4, bits per digit (BCD nibble).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  request scoring; accepted only in IDLE
- input_number  input  DIGITS*DW  guess; digit k = bits [DW*k+DW-1 : DW*k]
- target_number  input  DIGITS*DW  secret value, same layout
- busy  output  1  high from acceptance until done cycle inclusive
- done  output  1  one-cycle pulse, result valid
- check_result  output  2*DIGITS  [2*DIGITS-1:DIGITS] = exact-count thermometer; [DIGITS-1:0] = misplaced-count thermometer
- win  output  1  high with done when exact count == DIGITS

Behaviour:
- Reset: one clock with rst high. State becomes IDLE; busy=0, done=0, win=0, check_result=0, internal flags and counters cleared.
- Acceptance: start high at edge t0 in IDLE. Both operands are captured into internal registers, so later operand changes have no effect. State goes to EXACT.
- start outside IDLE is ignored and not queued.
- EXACT state: one digit per edge, k=0..DIGITS-1.
  - If g[k]==t[k]: increment exact count, set gused[k] and tused[k].
- CROSS state: one (i,j) pair per edge, i outer and j inner, both 0..DIGITS-1 (DIGITS² edges).
  - If !gused[i] && !tused[j] && g[i]==t[j]: increment misplaced count, set gused[i] and tused[j].
  - Each target digit matches at most once. Each guess digit counts at most once.
- FINISH state, one edge:
  - check_result <= {therm(exact), therm(misplaced)}, where therm(n) has the n LSBs set (e.g. 2 → 3'b011).
  - done <= 1; win <= (exact==DIGITS); state goes to IDLE.
- Latency: done and win are high only in cycle [t0+DIGITS+DIGITS²+1, +1), i.e. t0+13 for the default DIGITS=3.
- busy is low again in the cycle after done.
- A new start is accepted in the same cycle done is high, since the state is already IDLE.
- check_result holds its value until the next FINISH or rst. win drops with done.
- Nibbles above 9 are compared literally; no BCD validation.
- rst mid-operation aborts: no done pulse, outputs reset as above.
- Counts use clog2(DIGITS+1) bits and never overflow.

Optional Feature:
- Macro: GUESS_TRIES_EN.
- Defined: adds output tries [7:0], reset to 0. It increments on every done pulse, saturates at 8'hFF, and does not wrap.
- Not defined: tries port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package guess_pkg holds:
  - state enum IDLE/EXACT/CROSS/FINISH
  - DIGITS/DW defaults
  - function therm(count) returning a DIGITS-bit thermometer
- One natural sub-module, guess_pair_scan: the i/j index counter for CROSS, asserting last_pair on (DIGITS-1, DIGITS-1).
- The top FSM, operand registers and used-flags stay in guess_checker.

Test Plan:
- Exact hit: target 12'h123, guess 12'h123, start at t0 → done and win high only at t0+13; check_result=6'b111000; busy low at t0+14.
- Mixed: target 12'h123, guess 12'h321 → check_result=6'b001011 (1 exact, 2 misplaced), win=0.
- Duplicates: target 12'h100, guess 12'h111 → 6'b001000 (no double count). Target 12'h122, guess 12'h221 → 6'b001011.
- No match: target 12'h123, guess 12'h456 → 6'b000000. Result then holds across 20 idle cycles with changing inputs.
- Start while busy: second start at t0+4 with guess 12'h999 → ignored; single done at t0+13 with the first guess's result.
- Reset mid-op: rst at t0+5 → no done, check_result=0. New start at t0+8 → done at t0+21 with correct result. With GUESS_TRIES_EN, tries counts 1 after that.
